// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
//
// Owns the fetch PC, presents it to a combinational instruction memory every
// cycle, and queues {pc, instr, exception} entries in a small FIFO that feeds
// decode over a valid/ready handshake. A redirect flushes the FIFO and loads a
// new fetch PC. After any faulting entry is queued, fetching stops until the
// next redirect, while already-queued entries still drain.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   redirect_en, redirect_pc          flush FIFO and restart fetch at target
//   imem_addr                         memory address (always the fetch PC)
//   imem_instr, imem_exc_*            memory response for imem_addr
//   out_valid, out_ready              handshake to decode
//   out_pc, out_instr, out_exc_*      FIFO head (NOP values when empty)

module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   fpc_q, fpc_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  // FIFO storage; data needs no reset because count gates visibility.
  logic [63:0] ent_pc_q       [DEPTH];
  logic [31:0] ent_instr_q    [DEPTH];
  logic        ent_exc_en_q   [DEPTH];
  logic [3:0]  ent_exc_code_q [DEPTH];
  logic [63:0] ent_exc_val_q  [DEPTH];

  logic        not_empty;
  logic        pop;
  logic        push;
  logic        misaligned;
  logic [31:0] push_instr;
  logic        push_exc_en;
  logic [3:0]  push_exc_code;
  logic [63:0] push_exc_val;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty & out_ready & ~redirect_en;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
  assign push      = (state_q == RUN) & ~redirect_en & ((count_q < CNT_MAX) | pop);

  // A misaligned fetch PC overrides whatever the memory returned.
  assign misaligned    = (fpc_q[1:0] != 2'b00);
  assign push_instr    = misaligned ? NOP   : imem_instr;
  assign push_exc_en   = misaligned | imem_exc_en;
  assign push_exc_code = misaligned ? 4'd0  : imem_exc_code;
  assign push_exc_val  = misaligned ? fpc_q : imem_exc_val;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_en) begin
      state_d  = RUN;
      fpc_d    = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        fpc_d    = fpc_q + 64'd4;
        if (push_exc_en) begin
          state_d = FAULT;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      fpc_q    <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ent_pc_q[wr_ptr_q]       <= fpc_q;
      ent_instr_q[wr_ptr_q]    <= push_instr;
      ent_exc_en_q[wr_ptr_q]   <= push_exc_en;
      ent_exc_code_q[wr_ptr_q] <= push_exc_code;
      ent_exc_val_q[wr_ptr_q]  <= push_exc_val;
    end
  end

  assign imem_addr = fpc_q;
  assign out_valid = not_empty;

  always_comb begin
    out_pc       = 64'h0;
    out_instr    = NOP;
    out_exc_en   = 1'b0;
    out_exc_code = 4'd0;
    out_exc_val  = 64'h0;
    if (not_empty) begin
      out_pc       = ent_pc_q[rd_ptr_q];
      out_instr    = ent_instr_q[rd_ptr_q];
      out_exc_en   = ent_exc_en_q[rd_ptr_q];
      out_exc_code = ent_exc_code_q[rd_ptr_q];
      out_exc_val  = ent_exc_val_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl (DEPTH=2,
// RESET_PC=0). Instruction memory returns 32'hC0DE_0000 | addr[15:0] and can
// report an access fault at one programmable address.

module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;

  logic        fault_on;
  logic [63:0] fault_addr;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_ctrl #(.RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .imem_exc_en  (imem_exc_en),
    .imem_exc_code(imem_exc_code),
    .imem_exc_val (imem_exc_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_exc_en   (out_exc_en),
    .out_exc_code (out_exc_code),
    .out_exc_val  (out_exc_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    imem_instr    = 32'hC0DE_0000 | {16'h0, imem_addr[15:0]};
    imem_exc_en   = fault_on && (imem_addr == fault_addr);
    imem_exc_code = imem_exc_en ? 4'd1 : 4'd0;
    imem_exc_val  = imem_exc_en ? imem_addr : 64'h0;
  end

  // One line per accepted entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !redirect_en)
      $display("pop pc=%h instr=%h exc=%b code=%0d val=%h",
               out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
    fault_on = 1'b0; fault_addr = 64'h0;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (imem_addr !== 64'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else n_pass++;
    n_checks++; if (out_instr !== 32'h13) $display("FAIL reset_instr: got %h want 00000013", out_instr); else n_pass++;
    n_checks++; if (out_pc !== 64'h0 || out_exc_en !== 1'b0 || out_exc_code !== 4'd0 || out_exc_val !== 64'h0)
      $display("FAIL reset_fields: got pc=%h exc=%b code=%0d val=%h want zeros", out_pc, out_exc_en, out_exc_code, out_exc_val);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc [4];
    logic [31:0] exp_in [4];
    exp_pc[0] = 64'h0; exp_pc[1] = 64'h4; exp_pc[2] = 64'h8; exp_pc[3] = 64'hC;
    exp_in[0] = 32'hC0DE_0000; exp_in[1] = 32'hC0DE_0004;
    exp_in[2] = 32'hC0DE_0008; exp_in[3] = 32'hC0DE_000C;
    out_ready = 1'b1;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_first_cycle_valid: got %b want 0", out_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
      n_checks++; if (out_pc !== exp_pc[i]) $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, exp_pc[i]); else n_pass++;
      n_checks++; if (out_instr !== exp_in[i]) $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, exp_in[i]); else n_pass++;
      n_checks++; if (out_exc_en !== 1'b0) $display("FAIL stream_exc[%0d]: got %b want 0", i, out_exc_en); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    redirect_en = 1'b1; redirect_pc = 64'h0;
    step();
    redirect_en = 1'b0; out_ready = 1'b0;
    n_checks++; if (imem_addr !== 64'h0 || out_valid !== 1'b0)
      $display("FAIL bp_start: got addr=%h valid=%b want 0/0", imem_addr, out_valid); else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0)
        $display("FAIL bp_hold_head[%0d]: got valid=%b pc=%h want 1/0", i, out_valid, out_pc); else n_pass++;
      if (i >= 2) begin
        n_checks++; if (imem_addr !== 64'h8) $display("FAIL bp_addr_hold[%0d]: got %h want 8", i, imem_addr); else n_pass++;
      end
    end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h4) $display("FAIL bp_release_1: got valid=%b pc=%h want 1/4", out_valid, out_pc); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8) $display("FAIL bp_release_2: got valid=%b pc=%h want 1/8", out_valid, out_pc); else n_pass++;
    n_checks++; if (imem_addr !== 64'h10) $display("FAIL bp_release_addr: got %h want 10", imem_addr); else n_pass++;
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8) $display("FAIL rdf_full_head: got valid=%b pc=%h want 1/8", out_valid, out_pc); else n_pass++;
    redirect_en = 1'b1; redirect_pc = 64'h100; out_ready = 1'b1;
    step();
    redirect_en = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rdf_flush_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (imem_addr !== 64'h100) $display("FAIL rdf_addr: got %h want 100", imem_addr); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h100) $display("FAIL rdf_target: got valid=%b pc=%h want 1/100", out_valid, out_pc); else n_pass++;
    step();
    n_checks++; if (out_pc !== 64'h104) $display("FAIL rdf_next: got %h want 104", out_pc); else n_pass++;
  endtask

  task automatic test_mem_fault();
    fault_on = 1'b1; fault_addr = 64'h2000;
    redirect_en = 1'b1; redirect_pc = 64'h2000; out_ready = 1'b1;
    step();
    redirect_en = 1'b0;
    n_checks++; if (imem_addr !== 64'h2000) $display("FAIL mf_addr: got %h want 2000", imem_addr); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h2000) $display("FAIL mf_entry: got valid=%b pc=%h want 1/2000", out_valid, out_pc); else n_pass++;
    n_checks++; if (out_exc_en !== 1'b1 || out_exc_code !== 4'd1 || out_exc_val !== 64'h2000)
      $display("FAIL mf_exc: got exc=%b code=%0d val=%h want 1/1/2000", out_exc_en, out_exc_code, out_exc_val); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b0 || imem_addr !== 64'h2004)
        $display("FAIL mf_stopped[%0d]: got valid=%b addr=%h want 0/2004", i, out_valid, imem_addr); else n_pass++;
    end
    fault_on = 1'b0;
    redirect_en = 1'b1; redirect_pc = 64'h40;
    step();
    redirect_en = 1'b0;
    n_checks++; if (imem_addr !== 64'h40) $display("FAIL mf_resume_addr: got %h want 40", imem_addr); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_exc_en !== 1'b0)
      $display("FAIL mf_resume_entry: got valid=%b pc=%h exc=%b want 1/40/0", out_valid, out_pc, out_exc_en); else n_pass++;
  endtask

  task automatic test_misaligned();
    redirect_en = 1'b1; redirect_pc = 64'h102; out_ready = 1'b1;
    step();
    redirect_en = 1'b0;
    n_checks++; if (imem_addr !== 64'h102 || out_valid !== 1'b0)
      $display("FAIL mis_addr: got addr=%h valid=%b want 102/0", imem_addr, out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h102) $display("FAIL mis_entry: got valid=%b pc=%h want 1/102", out_valid, out_pc); else n_pass++;
    n_checks++; if (out_exc_en !== 1'b1 || out_exc_code !== 4'd0 || out_exc_val !== 64'h102)
      $display("FAIL mis_exc: got exc=%b code=%0d val=%h want 1/0/102", out_exc_en, out_exc_code, out_exc_val); else n_pass++;
    n_checks++; if (out_instr !== 32'h13) $display("FAIL mis_instr: got %h want 00000013", out_instr); else n_pass++;
    step(); step();
    n_checks++; if (out_valid !== 1'b0 || imem_addr !== 64'h106)
      $display("FAIL mis_stopped: got valid=%b addr=%h want 0/106", out_valid, imem_addr); else n_pass++;
  endtask

  task automatic test_reset_with_redirect();
    redirect_en = 1'b1; redirect_pc = 64'h200; out_ready = 1'b0;
    step();
    redirect_en = 1'b0;
    step(); step();
    n_checks++; if (out_valid !== 1'b1 || imem_addr !== 64'h208)
      $display("FAIL rr_filled: got valid=%b addr=%h want 1/208", out_valid, imem_addr); else n_pass++;
    rst = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h300;
    step();
    rst = 1'b0; redirect_en = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || imem_addr !== 64'h0)
      $display("FAIL rr_after_reset: got valid=%b addr=%h want 0/0", out_valid, imem_addr); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0)
      $display("FAIL rr_run: got valid=%b pc=%h want 1/0", out_valid, out_pc); else n_pass++;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    redirect_en = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_en = 1'b0;
    n_checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffffffffffc", imem_addr); else n_pass++;
    step();
    n_checks++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || imem_addr !== 64'h0)
      $display("FAIL wrap_top: got pc=%h addr=%h want fffffffffffffffc/0", out_pc, imem_addr); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_exc_en !== 1'b0)
      $display("FAIL wrap_zero: got valid=%b pc=%h exc=%b want 1/0/0", out_valid, out_pc, out_exc_en); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_mem_fault();
    test_misaligned();
    test_reset_with_redirect();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the combinational instruction memory and the decode stage. Owns the fetch PC, drives the memory address every cycle, captures instruction plus access-fault status into a small FIFO, and delivers entries to decode over a valid/ready handshake. Handles redirects (branches, traps, mret) by flushing the FIFO. Stops fetching after any fetch fault until the next redirect.

## Interface
- `RESET_PC`, default 64'h0: fetch PC loaded on reset.
- `DEPTH`, default 2: FIFO entries; a power of two, at least 2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `redirect_en` in 1: load a new fetch PC and flush the FIFO.
- `redirect_pc` in 64: target PC.
- `imem_addr` out 64: address to instruction memory; always equals `fpc`.
- `imem_instr` in 32: instruction from memory, combinational in `imem_addr`.
- `imem_exc_en` in 1: access fault from memory.
- `imem_exc_code` in 4: fault cause from memory.
- `imem_exc_val` in 64: fault value from memory.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_pc` out 64: head PC.
- `out_instr` out 32: head instruction.
- `out_exc_en` out 1: head carries a fault.
- `out_exc_code` out 4: head fault cause.
- `out_exc_val` out 64: head fault value.

## Operation
- State:
  - `fpc` (64 bits).
  - FIFO of DEPTH entries `{pc, instr, exc_en, exc_code, exc_val}`, with read pointer, write pointer and count.
  - FSM with two states: `RUN` and `FAULT`.
- `out_valid` = (count != 0). When the FIFO is empty, the `out_*` fields read as NOP: instr 32'h00000013, pc 0, exc fields 0.
- `pop` = `out_valid & out_ready & ~redirect_en`.
- `push` = `state==RUN & ~redirect_en & (count<DEPTH | pop)`. A simultaneous pop frees a slot for a push when the FIFO is full.
- On push, the FIFO captures:
  - `pc` = `fpc`.
  - `instr` = `imem_instr`.
  - Exception fields:
    - If `fpc[1:0] != 0`: exc_en=1, code=4'd0 (instruction address misaligned), val=`fpc`, instr=NOP.
    - Otherwise: the `imem_exc_*` inputs.
- `fpc` update on push: `fpc <= fpc + 4`, wrapping modulo 2^64.
- FSM transitions:
  - A pushed entry with exc_en=1 moves `RUN` to `FAULT`.
  - In `FAULT` there are no pushes and `fpc` holds. Already-queued entries, including the faulting one, still drain to decode normally.
- Redirect (`redirect_en=1`, not in reset):
  - count, read pointer and write pointer go to 0.
  - `fpc <= redirect_pc`.
  - state goes to `RUN`.
  - No push and no pop that cycle. A head shown on `out_*` that cycle is discarded even if `out_ready=1`.
- Reset: `rst` overrides redirect, push and pop.
- Count: count' = count + push - pop. Count never exceeds DEPTH and never underflows.

## Timing
- Reset values of registered state: `fpc`=RESET_PC, count=0, state=RUN.
- Reset values of outputs:
  - `out_valid`=0 and `out_*` = NOP values.
  - `imem_addr`=RESET_PC.
- Fetch latency: first `out_valid` appears 1 cycle after the first cycle with `rst`=0. Entry for address A is visible the cycle after `imem_addr`=A.
- Redirect penalty:
  - Redirect asserted in cycle N: `imem_addr`=redirect_pc in N+1.
  - `out_valid` for the target entry in N+2.
- Sustained throughput: 1 instruction per cycle with `out_ready` held high.
- Back-pressure: `out_*` stay stable while `out_valid=1 & out_ready=0`. Fetch continues until the FIFO is full, then `imem_addr` holds.
- Fault stop:
  - A faulting entry pushed at the edge ending cycle N causes no push in N+1.
  - `imem_addr` holds the next PC (faulting PC + 4) until a redirect.
- Outputs have no combinational path from `out_ready` or `redirect_en`. `imem_addr` comes from the register only.

## Test plan
- Reset release, RESET_PC=0, `out_ready`=1, memory holds words W0..W3:
  - `out_pc` must go 0, 4, 8, 12 on consecutive cycles starting 1 cycle after reset.
  - Instructions must be W0..W3, with exc_en=0 throughout.
- Back-pressure: hold `out_ready`=0 for 5 cycles with DEPTH=2, then release:
  - count saturates at 2 and `imem_addr` holds at 8.
  - `out_pc` stays 0 until release.
  - After release the order is 0, 4, 8 with no gaps.
- Redirect with full FIFO, redirect_pc=0x100, `out_ready`=1 in the same cycle:
  - The popped head is discarded.
  - Next cycle `out_valid`=0 and `imem_addr`=0x100.
  - The cycle after, `out_pc`=0x100.
- Memory access fault:
  - Memory returns exc_en=1, code=1, val=0x2000 at PC 0x2000.
  - Decode receives that entry with code 1 and val 0x2000.
  - `out_valid` then stays 0 indefinitely.
  - A redirect to 0x40 resumes fetching at 0x40.
- Misaligned redirect to 0x102:
  - One entry with pc=0x102, exc_en=1, code=0, val=0x102, instr=NOP.
  - Fetching then stops.
- Reset asserted mid-stream, together with `redirect_en`:
  - Next cycle count=0, `imem_addr`=RESET_PC, state RUN. The redirect is ignored.
- Wrap-around: redirect to 64'hFFFF_FFFF_FFFF_FFFC:
  - The following entry has pc=0.
